// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - state_e         : fetch FSM states
//   - OP_*            : opcodes the next-PC logic cares about
//   - DEFAULT_RESET_PC: PC loaded on reset unless overridden
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_ISSUE   = 2'd1,
        S_RESOLVE = 2'd2
    } state_e;

    localparam logic [5:0] OP_BEQ = 6'b100011;
    localparam logic [5:0] OP_BNE = 6'b100111;
    localparam logic [5:0] OP_J   = 6'b111000;
    localparam logic [5:0] OP_JAL = 6'b111001;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
//   pc_plus4 (in,32) : address of the sequential successor
//   instr    (in,32) : current instruction word
//   branch   (in,1)  : decoder says beq/bne
//   jump     (in,1)  : decoder says j/jal (wins over branch)
//   zero     (in,1)  : ALU zero flag for the current instruction
//   pc_next  (out,32): selected next PC (low bits cleared by the caller)
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc_next
);

    logic [31:0] br_off;
    logic [31:0] jmp_tgt;
    logic        taken;
    logic [4:0]  unused_opc;

    // Opcode bit 2 separates bne (100111) from beq (100011).
    assign taken      = branch & (instr[28] ? ~zero : zero);
    assign br_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jmp_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign unused_opc = {instr[31:29], instr[27:26]};

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = jmp_tgt;
        end else if (taken) begin
            pc_next = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage feeding the opcode decoder.
// One instruction in flight: request -> issue to decoder -> wait for execute.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   imem_req/imem_addr    : level read request to instruction memory, addr = pc
//   imem_valid/imem_rdata : memory response, honoured only while requesting
//   instr/opcode          : latched instruction and its opcode field
//   instr_valid/ready     : handshake towards the decoder
//   branch/jump/zero      : control for next-PC, sampled with ex_done
//   ex_done               : execute complete, honoured only in S_RESOLVE
//   pc/pc_plus4           : current PC and its successor (jal link value)
//   retired               : completed-instruction count (wraps)
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        ex_done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, instr_q, retired_q;
    logic        start_q;
    logic [31:0] pc_next;
    logic        fetch_hit;
    logic        resolve_hit;

    // start_q holds off the first request for one cycle after reset release,
    // so a response left over from before reset can never be latched.
    assign fetch_hit   = (state_q == S_REQ) && start_q && imem_valid;
    assign resolve_hit = (state_q == S_RESOLVE) && ex_done;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .pc_next  (pc_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:     if (fetch_hit)   state_d = S_ISSUE;
            S_ISSUE:   if (instr_ready) state_d = S_RESOLVE;
            S_RESOLVE: if (ex_done)     state_d = S_REQ;
            default:                    state_d = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = (state_q == S_REQ) && start_q;
        instr_valid = (state_q == S_ISSUE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            start_q <= 1'b1;
            if (fetch_hit) begin
                instr_q <= imem_rdata;
            end
            if (resolve_hit) begin
                pc_q      <= pc_next & ~32'd3;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];
    assign retired   = retired_q;

endmodule
